// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back data, holds the GPR file and HI/LO, and handles the overflow trap and flush.
// Optional WB_RETIRE_CNT_EN adds the o_retired counter of retired (non-trapping) bundles.
module wb_stage #(
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [31:0] RESET_PC_EPC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_reg_write,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_hilo_sel,
  input  logic        i_ovf_trap,
  input  logic        i_overflow,
  input  logic        i_hi_write,
  input  logic        i_lo_write,
  input  logic [31:0] i_Dm,
  input  logic [31:0] i_result,
  input  logic [31:0] i_lo_result,
  input  logic [4:0]  i_Rw,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_ra,
  input  logic [4:0]  i_rb,
  output logic [31:0] o_da,
  output logic [31:0] o_db,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_flush,
  output logic [31:0] o_epc,
  output logic        o_trap
`ifdef WB_RETIRE_CNT_EN
  , output logic [31:0] o_retired
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] gpr [32];

  logic        retire, trap, commit, gpr_we;
  logic [31:0] wb_data;

  assign retire = (state == RUN) && i_valid;
  assign trap   = retire && i_ovf_trap && i_overflow;
  assign commit = retire && !trap;
  assign gpr_we = commit && i_reg_write && (i_Rw != 5'd0);

  // HI/LO move uses the register values from before this edge.
  always_comb begin
    wb_data = i_result;
    case (i_wb_sel)
      2'b00: wb_data = i_result;
      2'b01: wb_data = i_Dm;
      2'b10: wb_data = i_pc + 32'd8;
      2'b11: wb_data = i_hilo_sel ? o_hi : o_lo;
    endcase
  end

  always_comb begin
    o_da = '0;
    if (i_ra != 5'd0) o_da = (gpr_we && i_ra == i_Rw) ? wb_data : gpr[i_ra];
  end

  always_comb begin
    o_db = '0;
    if (i_rb != 5'd0) o_db = (gpr_we && i_rb == i_Rw) ? wb_data : gpr[i_rb];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      cnt     <= '0;
      o_hi    <= '0;
      o_lo    <= '0;
      o_epc   <= RESET_PC_EPC;
      o_flush <= 1'b0;
      o_trap  <= 1'b0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      case (state)
        RUN: begin
          o_trap <= trap;
          if (trap) begin
            state   <= FLUSH;
            cnt     <= 4'(FLUSH_CYCLES - 1);
            o_flush <= 1'b1;
            o_epc   <= i_pc;
          end else if (commit) begin
            if (gpr_we)     gpr[i_Rw] <= wb_data;
            if (i_hi_write) o_hi      <= i_result;
            if (i_lo_write) o_lo      <= i_lo_result;
          end
        end
        FLUSH: begin
          o_trap <= 1'b0;
          if (cnt == 4'd0) begin
            state   <= RUN;
            o_flush <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        o_retired <= '0;
    else if (commit) o_retired <= o_retired + 32'd1;
  end
`endif

endmodule
